round_sequencer: RTL

ROUND_SEQUENCER -- requirements
Module: round_sequencer

---
 rtl/round_seq_pkg.sv | 18 +
 rtl/result_hold_counter.sv | 35 +++
 rtl/round_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/round_seq_pkg.sv
// Shared types and constants for the arithmetic-game round sequencer.
package round_seq_pkg;

   localparam int OP_W         = 4;
   localparam int SUM_W        = 5;
   localparam int STRIKE_LIMIT = 3;

   typedef enum logic [2:0] {
      IDLE,
      DRAW,
      LATCH,
      PLAY,
      CHECK,
      HOLD,
      DONE
   } state_t;

endpackage

// File: rtl/result_hold_counter.sv
// Down-counter that times the result display. It reloads while idle and counts
// while enabled, and done_o flags the last enabled cycle.
module result_hold_counter #(
   parameter int CYCLES = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic en_i,
   output logic done_o
);

   localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = LOAD_VAL;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= LOAD_VAL;
      else
         cnt_q <= cnt_d;
   end

   assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/round_sequencer.sv
// Game round sequencer: draws operands, waits for an answer or timeout, shows
// the result for HOLD_CYCLES, and scores the game. STRIKE_LIMIT_EN adds a miss limit.
//
// state | meaning
// IDLE  | locked or waiting for start
// DRAW  | request random operand, reload digit timer
// LATCH | capture operands A and B
// PLAY  | timer running, waiting for answer or timeout
// CHECK | compare answer with A+B, update score
// HOLD  | show green/red result
// DONE  | game over, score frozen
module round_sequencer
   import round_seq_pkg::*;
#(
   parameter int ROUNDS      = 8,
   parameter int HOLD_CYCLES = 50000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             unlocked,
   input  logic             start,
   input  logic [OP_W-1:0]  rng_value,
   input  logic [OP_W-1:0]  operand_b,
   input  logic             answer_load,
   input  logic [SUM_W-1:0] answer,
   input  logic             time_out,
   output logic             rng_req,
   output logic             timer_reload,
   output logic             timer_en,
   output logic             green_led,
   output logic             red_led,
   output logic [OP_W-1:0]  score,
   output logic [OP_W-1:0]  round_num,
   output logic             game_over
);

   localparam logic [OP_W-1:0] ROUNDS_L = OP_W'(ROUNDS);

   state_t           state_q, state_d;
   logic [OP_W-1:0]  score_q, score_d;
   logic [OP_W-1:0]  round_q, round_d;
   logic [OP_W-1:0]  a_q, a_d;
   logic [OP_W-1:0]  b_q, b_d;
   logic [SUM_W-1:0] ans_q, ans_d;
   logic             good_q, good_d;
   logic [SUM_W-1:0] sum;
   logic             match;
   logic             hold_done;
   logic             new_game;
   logic             abort;
   logic             strike_hit;

   assign sum      = SUM_W'(a_q) + SUM_W'(b_q);
   assign match    = (ans_q == sum);
   assign new_game = start && unlocked && ((state_q == IDLE) || (state_q == DONE));
   assign abort    = !unlocked && (state_q != IDLE);

   result_hold_counter #(.CYCLES(HOLD_CYCLES)) u_hold (
      .clk    (clk),
      .rst    (rst),
      .load_i (state_q != HOLD),
      .en_i   (state_q == HOLD),
      .done_o (hold_done)
   );

`ifdef STRIKE_LIMIT_EN
   logic [1:0] miss_q, miss_d;
   logic       miss_evt;

   assign miss_evt = ((state_q == PLAY) && !answer_load && time_out) ||
                     ((state_q == CHECK) && !match);

   always_comb begin
      miss_d = miss_q;
      if (abort || new_game)
         miss_d = '0;
      else if (miss_evt && (miss_q != 2'd3))
         miss_d = miss_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         miss_q <= '0;
      else
         miss_q <= miss_d;
   end

   assign strike_hit = (miss_q == 2'(STRIKE_LIMIT));
`else
   assign strike_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      round_d = round_q;
      a_d     = a_q;
      b_d     = b_q;
      ans_d   = ans_q;
      good_d  = good_q;
      case (state_q)
         IDLE: begin
            if (new_game) begin
               score_d = '0;
               round_d = '0;
               state_d = DRAW;
            end
         end
         DRAW:  state_d = LATCH;
         LATCH: begin
            a_d     = rng_value;
            b_d     = operand_b;
            state_d = PLAY;
         end
         PLAY: begin
            if (answer_load) begin
               ans_d   = answer;
               state_d = CHECK;
            end else if (time_out) begin
               good_d  = 1'b0;
               state_d = HOLD;
            end
         end
         CHECK: begin
            good_d = match;
            if (match && (score_q != '1))
               score_d = score_q + 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (hold_done) begin
               round_d = round_q + 1'b1;
               state_d = ((round_d == ROUNDS_L) || strike_hit) ? DONE : DRAW;
            end
         end
         DONE: begin
            if (new_game) begin
               score_d = '0;
               round_d = '0;
               state_d = DRAW;
            end
         end
         default: state_d = IDLE;
      endcase
      // Losing access wins over everything and wipes the visible game state.
      if (abort) begin
         state_d = IDLE;
         score_d = '0;
         round_d = '0;
         a_d     = '0;
         b_d     = '0;
         ans_d   = '0;
         good_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         score_q <= '0;
         round_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ans_q   <= '0;
         good_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         round_q <= round_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ans_q   <= ans_d;
         good_q  <= good_d;
      end
   end

   assign rng_req      = (state_q == DRAW);
   assign timer_reload = (state_q == DRAW);
   assign timer_en     = (state_q == PLAY);
   assign green_led    = (state_q == HOLD) && good_q;
   assign red_led      = (state_q == HOLD) && !good_q;
   assign game_over    = (state_q == DONE);
   assign score        = score_q;
   assign round_num    = round_q;

endmodule
